assoc_cache_ctrl: RTL and testbench

- Parametrised successor to the core's direct-mapped cache path.
- Single block holding tag/valid/dirty/data arrays plus the miss FSM: a WAYS-way set-associative, write-back, write-allocate data cache.
- Sits between the core's load/store port and the byte-lane data memory, which has a fixed multi-cycle latency.
- Stalls the core on a miss.

---
 rtl/assoc_cache_ctrl.sv | 270 +++++++++++++++++++++++++++
 tb/tb_assoc_cache_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/assoc_cache_ctrl.sv
// assoc_cache_ctrl: WAYS-way set-associative, write-back, write-allocate data
// cache with a one-word line, sitting between the core load/store port and a
// fixed-latency data memory. The core is stalled while a miss is serviced.
//
// Ports:
//   clk, rst_b           clock (rising edge) / asynchronous active-low reset
//   req, we, is_byte     core request valid, store, byte-lane store
//   addr, wdata          byte address, store data (byte stores use wdata[7:0])
//   rdata, ready, stall  load data, request completes this cycle, req & ~ready
//   mem_addr             word-aligned memory address
//   mem_data_in          write data to memory
//   mem_data_out         read data from memory (valid in last read cycle)
//   mem_write_en         memory write strobe
//   hit_count            hits counter
//   miss_count           misses counter
//
// Core handshake: a request is presented by holding req high; it completes in
// the cycle where ready=1. While stall=1 the core keeps req, we, is_byte, addr
// and wdata stable. Dropping req during a miss does not cancel the line fill.
//
// Optional build macro: ASSOC_CACHE_STATS_EN enables the hit/miss counters;
// without it both counter outputs are tied to 0.

module assoc_cache_ctrl #(
    parameter int XLEN        = 32,
    parameter int SETS        = 64,
    parameter int WAYS        = 2,
    parameter int MEM_LATENCY = 4
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            req,
    input  logic            we,
    input  logic            is_byte,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata,
    output logic            ready,
    output logic            stall,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_data_in,
    input  logic [XLEN-1:0] mem_data_out,
    output logic            mem_write_en,
    output logic [31:0]     hit_count,
    output logic [31:0]     miss_count
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = XLEN - 2 - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_REFILL    = 2'd2,
        S_FILL      = 2'd3
    } state_t;

    state_t state, next_state;

    // Storage arrays
    logic [TAG_W-1:0] tag_arr   [SETS][WAYS];
    logic [XLEN-1:0]  data_arr  [SETS][WAYS];
    logic             valid_arr [SETS][WAYS];
    logic             dirty_arr [SETS][WAYS];
    logic [WAY_W-1:0] rr_ptr    [SETS];

    // Miss bookkeeping
    logic [CNT_W-1:0] lat_cnt;
    logic [WAY_W-1:0] victim_q;
    logic             victim_from_ptr_q;
    logic [XLEN-1:0]  fill_data_q;

    // Address split
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [1:0]       lane;

    assign idx  = addr[2 +: IDX_W];
    assign tag  = addr[XLEN-1 -: TAG_W];
    assign lane = addr[1:0];

    // Lookup across all ways of the addressed set
    logic             hit_any;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] victim_c;
    logic             victim_from_ptr_c;
    logic             miss_start;
    logic [XLEN-1:0]  store_word;
    logic [WAY_W-1:0] ptr_next;
    logic             lat_done;

    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_arr[idx][w] && (tag_arr[idx][w] == tag)) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
        end

        // Scanning downwards leaves the lowest-index invalid way selected;
        // the round-robin pointer is used only when the set is full.
        victim_c          = rr_ptr[idx];
        victim_from_ptr_c = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_arr[idx][w]) begin
                victim_c          = WAY_W'(w);
                victim_from_ptr_c = 1'b0;
            end
        end
    end

    always_comb begin
        store_word = data_arr[idx][hit_way];
        if (is_byte) begin
            store_word[{lane, 3'b000} +: 8] = wdata[7:0];
        end else begin
            store_word = wdata;
        end
    end

    assign ptr_next   = (rr_ptr[idx] == WAY_W'(WAYS - 1)) ? '0 : rr_ptr[idx] + WAY_W'(1);
    assign miss_start = (state == S_IDLE) && req && !hit_any;
    assign lat_done   = (lat_cnt == '0);

    // FSM: state register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM: next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (miss_start) begin
                    next_state = dirty_arr[idx][victim_c] ? S_WRITEBACK : S_REFILL;
                end
            end
            S_WRITEBACK: if (lat_done) next_state = S_REFILL;
            S_REFILL:    if (lat_done) next_state = S_FILL;
            S_FILL:      next_state = S_IDLE;
            default:     next_state = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        ready        = 1'b0;
        rdata        = '0;
        mem_addr     = '0;
        mem_data_in  = '0;
        mem_write_en = 1'b0;
        case (state)
            S_IDLE: begin
                ready = req && hit_any;
                if (ready && !we) begin
                    rdata = data_arr[idx][hit_way];
                end
            end
            S_WRITEBACK: begin
                mem_addr     = {tag_arr[idx][victim_q], idx, 2'b00};
                mem_data_in  = data_arr[idx][victim_q];
                mem_write_en = 1'b1;
            end
            S_REFILL: begin
                mem_addr = {addr[XLEN-1:2], 2'b00};
            end
            default: ;
        endcase
        // Gated by reset so the core sees no stall while the cache is held in reset.
        stall = req && !ready && rst_b;
    end

    // Shared latency counter, reloaded whenever WRITEBACK or REFILL is entered.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            lat_cnt <= '0;
        end else if ((next_state != state) &&
                     ((next_state == S_WRITEBACK) || (next_state == S_REFILL))) begin
            lat_cnt <= CNT_W'(MEM_LATENCY - 1);
        end else if (!lat_done) begin
            lat_cnt <= lat_cnt - CNT_W'(1);
        end
    end

    // Victim selection is frozen at the miss; refill data captured in the final read cycle.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            victim_q          <= '0;
            victim_from_ptr_q <= 1'b0;
            fill_data_q       <= '0;
        end else begin
            if (miss_start) begin
                victim_q          <= victim_c;
                victim_from_ptr_q <= victim_from_ptr_c;
            end
            if ((state == S_REFILL) && lat_done) begin
                fill_data_q <= mem_data_out;
            end
        end
    end

    // Valid / dirty bits and replacement pointers
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int s = 0; s < SETS; s++) begin
                rr_ptr[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    valid_arr[s][w] <= 1'b0;
                    dirty_arr[s][w] <= 1'b0;
                end
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (ready && we) dirty_arr[idx][hit_way] <= 1'b1;
                end
                S_WRITEBACK: begin
                    if (lat_done) dirty_arr[idx][victim_q] <= 1'b0;
                end
                S_FILL: begin
                    valid_arr[idx][victim_q] <= 1'b1;
                    dirty_arr[idx][victim_q] <= 1'b0;
                    if (victim_from_ptr_q) rr_ptr[idx] <= ptr_next;
                end
                default: ;
            endcase
        end
    end

    // Tag and data storage carry no reset; valid bits qualify them.
    always_ff @(posedge clk) begin
        if ((state == S_IDLE) && ready && we) begin
            data_arr[idx][hit_way] <= store_word;
        end else if (state == S_FILL) begin
            data_arr[idx][victim_q] <= fill_data_q;
            tag_arr[idx][victim_q]  <= tag;
        end
    end

`ifdef ASSOC_CACHE_STATS_EN
    logic [31:0] hit_q;
    logic [31:0] miss_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (ready)      hit_q  <= hit_q + 32'd1;
            if (miss_start) miss_q <= miss_q + 32'd1;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Bench for assoc_cache_ctrl: directed steps followed by random traffic, all
// checked against a set/way-level reference model of the cache contents.

module tb_assoc_cache_ctrl;

    localparam int L     = 4;
    localparam int SETS  = 64;
    localparam int WAYS  = 2;
    localparam int IDX_W = 6;

    // clock / reset
    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic        is_byte = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready;
    logic        stall;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out = '0;
    logic        mem_write_en;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    always #5 clk = ~clk;

    assoc_cache_ctrl #(
        .XLEN(32), .SETS(SETS), .WAYS(WAYS), .MEM_LATENCY(L)
    ) dut (
        .clk(clk), .rst_b(rst_b), .req(req), .we(we), .is_byte(is_byte),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .stall(stall),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .mem_write_en(mem_write_en), .hit_count(hit_count), .miss_count(miss_count)
    );

    // memory model: word store, writes committed on each strobed cycle
    logic [31:0] mem [int unsigned];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    always @(negedge clk) begin
        if (mem_write_en === 1'b1) mem[mem_addr] = mem_data_in;
        mem_data_out = mem_rd(mem_addr);
    end

    // scoreboard counters
    int checks = 0;
    int failures = 0;
    int m_hits = 0;
    int m_misses = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // reference model: contents of every set, by way
    bit          m_valid [SETS][WAYS];
    bit          m_dirty [SETS][WAYS];
    int unsigned m_tag   [SETS][WAYS];
    logic [31:0] m_data  [SETS][WAYS];
    int unsigned m_ptr   [SETS];

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
                m_tag[s][w]   = 0;
                m_data[s][w]  = '0;
            end
        end
        m_hits = 0;
        m_misses = 0;
    endtask

    task automatic model_access(input bit w, input bit b, input logic [31:0] a,
                                input logic [31:0] d, output int lat, output bit wb,
                                output logic [31:0] wb_addr, output logic [31:0] wb_data,
                                output logic [31:0] rd_exp);
        int unsigned idx;
        int unsigned tg;
        int way;
        int v;
        bit from_ptr;
        logic [31:0] word;
        idx = (a >> 2) % SETS;
        tg  = a >> (2 + IDX_W);
        way = -1;
        wb = 0; wb_addr = '0; wb_data = '0; lat = 0; rd_exp = '0;
        for (int i = 0; i < WAYS; i++)
            if (m_valid[idx][i] && m_tag[idx][i] == tg) way = i;
        if (way < 0) begin
            v = -1;
            for (int i = WAYS - 1; i >= 0; i--)
                if (!m_valid[idx][i]) v = i;
            from_ptr = (v < 0);
            if (v < 0) v = int'(m_ptr[idx]);
            if (m_valid[idx][v] && m_dirty[idx][v]) begin
                wb = 1;
                wb_addr = (m_tag[idx][v] * SETS + idx) * 4;
                wb_data = m_data[idx][v];
            end
            lat = wb ? 2 * L + 2 : L + 2;
            m_data[idx][v]  = mem_rd(a & 32'hFFFF_FFFC);
            m_tag[idx][v]   = tg;
            m_valid[idx][v] = 1;
            m_dirty[idx][v] = 0;
            if (from_ptr) m_ptr[idx] = (m_ptr[idx] + 1) % WAYS;
            m_misses++;
            way = v;
        end
        word = m_data[idx][way];
        if (w) begin
            if (b) word[8 * (a % 4) +: 8] = d[7:0];
            else   word = d;
            m_data[idx][way]  = word;
            m_dirty[idx][way] = 1;
        end else begin
            rd_exp = word;
        end
    endtask

    // driver: one complete access, called just after a rising edge
    logic [31:0] last_rdata;

    task automatic do_access(input bit w, input bit b, input logic [31:0] a,
                             input logic [31:0] d);
        int lat;
        bit wb;
        logic [31:0] wb_addr, wb_data, rd_exp, line;
        int stalls, wb_cyc, wb_bad, rf_cyc, bad_stall;
        bit done;
        model_access(w, b, a, d, lat, wb, wb_addr, wb_data, rd_exp);
        line = a & 32'hFFFF_FFFC;
        stalls = 0; wb_cyc = 0; wb_bad = 0; rf_cyc = 0; bad_stall = 0; done = 0;
        req = 1'b1; we = w; is_byte = b; addr = a; wdata = d;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (stall !== (req & ~ready)) bad_stall++;
            if (ready === 1'b1) begin
                done = 1;
                last_rdata = rdata;
                break;
            end
            stalls++;
            if (mem_write_en === 1'b1) begin
                wb_cyc++;
                if (mem_addr !== wb_addr || mem_data_in !== wb_data) wb_bad++;
            end else if (mem_addr === line) begin
                rf_cyc++;
            end
        end
        chk($sformatf("ready_seen@%h", a), 32'(done), 32'd1);
        chk($sformatf("latency@%h", a), 32'(stalls), 32'(lat));
        chk($sformatf("wb_cycles@%h", a), 32'(wb_cyc), wb ? 32'(L) : 32'd0);
        chk($sformatf("wb_addr_data_errs@%h", a), 32'(wb_bad), 32'd0);
        chk($sformatf("refill_cycles@%h", a), 32'(rf_cyc), (lat > 0) ? 32'(L) : 32'd0);
        chk($sformatf("stall_rule_errs@%h", a), 32'(bad_stall), 32'd0);
        if (!w) chk($sformatf("rdata@%h", a), last_rdata, rd_exp);
        m_hits++;
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'b0; is_byte = 1'b0;
    endtask

    initial begin
        int lat;
        bit wb;
        logic [31:0] wa, wd, re;
        int nwb;
        logic [31:0] ra;

        model_reset();
        mem[32'h100] = 32'hDEAD_BEEF;

        // reset state
        @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_write_en}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_hit_count", hit_count, 32'd0);
        chk("rst_miss_count", miss_count, 32'd0);
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk);
        #1;

        // clean miss then same-cycle hit
        do_access(0, 0, 32'h100, 32'h0);
        chk("first_load_word", last_rdata, 32'hDEAD_BEEF);
        do_access(0, 0, 32'h100, 32'h0);

        // byte store into lane 1, no memory traffic
        do_access(1, 1, 32'h101, 32'h0000_00AA);
        do_access(0, 0, 32'h100, 32'h0);
        chk("byte_store_word", last_rdata, 32'hDEAD_AAEF);

        // second way of set 0, then dirty eviction and round robin
        do_access(0, 0, 32'h200, 32'h0);
        do_access(0, 0, 32'h100, 32'h0);
        do_access(0, 0, 32'h200, 32'h0);
        do_access(0, 0, 32'h300, 32'h0);
        do_access(0, 0, 32'h400, 32'h0);
        do_access(0, 0, 32'h300, 32'h0);
        do_access(0, 0, 32'h200, 32'h0);
        chk("evicted_word_in_mem", mem_rd(32'h100), 32'hDEAD_AAEF);

        // req dropped after the miss starts: the line still fills
        model_access(0, 0, 32'h404, 32'h0, lat, wb, wa, wd, re);
        req = 1'b1; we = 1'b0; is_byte = 1'b0; addr = 32'h404;
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (2 * L + 6) @(posedge clk);
        #1;
        do_access(0, 0, 32'h404, 32'h0);

        // reset during the second writeback cycle
        do_access(1, 0, 32'h108, $urandom);
        do_access(1, 0, 32'h208, $urandom);
        model_access(0, 0, 32'h308, 32'h0, lat, wb, wa, wd, re);
        req = 1'b1; we = 1'b0; addr = 32'h308;
        nwb = 0;
        for (int c = 0; c < 40 && nwb < 2; c++) begin
            @(negedge clk);
            if (mem_write_en === 1'b1) nwb++;
        end
        chk("rst_wb_reached", 32'(nwb), 32'd2);
        #1 rst_b = 1'b0;
        #1;
        chk("abort_mem_we", {31'd0, mem_write_en}, 32'd0);
        chk("abort_stall", {31'd0, stall}, 32'd0);
        chk("abort_ready", {31'd0, ready}, 32'd0);
        chk("abort_mem_addr", mem_addr, 32'd0);
        req = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        do_access(0, 0, 32'h100, 32'h0);

        // random traffic over a few conflicting sets
        for (int i = 0; i < 300; i++) begin
            ra = ($urandom_range(1, 6) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, $urandom);
        end

`ifdef ASSOC_CACHE_STATS_EN
        chk("hit_count", hit_count, 32'(m_hits));
        chk("miss_count", miss_count, 32'(m_misses));
`else
        chk("hit_count_tied", hit_count, 32'd0);
        chk("miss_count_tied", miss_count, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
